apu_note_sequencer: RTL and testbench

// Frame-locked step sequencer that drives the pitch input of the AudioProcessingUnit.

---
 rtl/apu_note_sequencer.sv | 161 ++++++++++++++++
 tb/tb_apu_note_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/apu_note_sequencer.sv
// apu_note_sequencer: frame-locked looping step sequencer feeding the APU pitch input.
// A programmable pattern of STEPS pitches is played one step every (tempo+1) frames;
// the gate is dropped for the last frame of each multi-frame step to separate notes.
module apu_note_sequencer #(
    parameter int STEPS   = 16,
    parameter int PITCH_W = 8,
    parameter int ADDR_W  = $clog2(STEPS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               run,
    input  logic [3:0]         tempo,
    input  logic [ADDR_W-1:0]  loop_last,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PITCH_W-1:0] wr_data,
    output logic [PITCH_W-1:0] pitch_out,
    output logic               gate_out,
    output logic [ADDR_W-1:0]  step_idx,
    output logic               step_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [3:0]          frame_cnt_r, frame_cnt_s;
    logic [3:0]          tempo_q_r, tempo_q_s;
    logic [ADDR_W-1:0]   step_idx_r, step_idx_s;
    logic [PITCH_W-1:0]  pitch_r, pitch_s;
    logic                gate_r, gate_s;
    logic                pulse_r, pulse_s;
    logic [PITCH_W-1:0]  pattern_r [STEPS];

    logic                load_s;
    logic [ADDR_W-1:0]   load_idx_s;
    logic [PITCH_W-1:0]  load_val_s;

    // Entry fetched on a step load; a same-cycle write to that entry wins.
    always_comb begin
        load_val_s = pattern_r[load_idx_s];
        if (wr_en && (wr_addr == load_idx_s)) begin
            load_val_s = wr_data;
        end else begin
            load_val_s = pattern_r[load_idx_s];
        end
    end

    // Next-state and next-output logic of the play FSM.
    always_comb begin
        state_s     = state_r;
        frame_cnt_s = frame_cnt_r;
        tempo_q_s   = tempo_q_r;
        step_idx_s  = step_idx_r;
        pitch_s     = pitch_r;
        gate_s      = gate_r;
        pulse_s     = 1'b0;
        load_s      = 1'b0;
        load_idx_s  = step_idx_r;
        case (state_r)
            IDLE: begin
                if (run) begin
                    state_s     = PLAY;
                    frame_cnt_s = 4'd0;
                    tempo_q_s   = tempo;
                    load_s      = 1'b1;
                    load_idx_s  = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            PLAY, GAP: begin
                if (!run) begin
                    state_s     = IDLE;
                    frame_cnt_s = 4'd0;
                    step_idx_s  = '0;
                    pitch_s     = '0;
                    gate_s      = 1'b0;
                end else if (frame_tick) begin
                    if (frame_cnt_r == tempo_q_r) begin
                        state_s     = PLAY;
                        frame_cnt_s = 4'd0;
                        tempo_q_s   = tempo;
                        load_s      = 1'b1;
                        if (step_idx_r >= loop_last) begin
                            load_idx_s = '0;
                        end else begin
                            load_idx_s = step_idx_r + ADDR_W'(1);
                        end
                    end else if ((state_r == PLAY) && (tempo_q_r != 4'd0) &&
                                 (frame_cnt_r == (tempo_q_r - 4'd1))) begin
                        state_s     = GAP;
                        gate_s      = 1'b0;
                        frame_cnt_s = frame_cnt_r + 4'd1;
                    end else begin
                        frame_cnt_s = frame_cnt_r + 4'd1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s     = IDLE;
                frame_cnt_s = 4'd0;
                step_idx_s  = '0;
                pitch_s     = '0;
                gate_s      = 1'b0;
            end
        endcase
        if (load_s) begin
            step_idx_s = load_idx_s;
            pitch_s    = load_val_s;
            gate_s     = (load_val_s != '0);
            pulse_s    = 1'b1;
        end else begin
            pulse_s    = 1'b0;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            frame_cnt_r <= 4'd0;
            tempo_q_r   <= 4'd0;
            step_idx_r  <= '0;
            pitch_r     <= '0;
            gate_r      <= 1'b0;
            pulse_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            frame_cnt_r <= frame_cnt_s;
            tempo_q_r   <= tempo_q_s;
            step_idx_r  <= step_idx_s;
            pitch_r     <= pitch_s;
            gate_r      <= gate_s;
            pulse_r     <= pulse_s;
        end
    end

    // Pattern storage, writable in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                pattern_r[i] <= '0;
            end
        end else if (wr_en) begin
            pattern_r[wr_addr] <= wr_data;
        end
    end

    assign pitch_out  = pitch_r;
    assign gate_out   = gate_r;
    assign step_idx   = step_idx_r;
    assign step_pulse = pulse_r;

endmodule

// File: tb/tb_apu_note_sequencer.sv
// Testbench for apu_note_sequencer: directed scenarios plus random play,
// every cycle compared against a frame-counting behavioural model.
module tb_apu_note_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       run = 1'b0;
    logic [3:0] tempo = 4'd0;
    logic [3:0] loop_last = 4'd0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [7:0] wr_data = 8'd0;
    logic [7:0] pitch_out;
    logic       gate_out;
    logic [3:0] step_idx;
    logic       step_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: a step lasts m_dur frames; m_elapsed counts ticks seen in it
    bit m_play;
    int m_idx, m_elapsed, m_dur, m_pitch, m_gate, m_pulse;
    int m_pat [16];

    apu_note_sequencer dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run),
        .tempo(tempo), .loop_last(loop_last), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .pitch_out(pitch_out),
        .gate_out(gate_out), .step_idx(step_idx), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_play = 0; m_idx = 0; m_elapsed = 0; m_dur = 1;
        m_pitch = 0; m_gate = 0; m_pulse = 0;
        for (int i = 0; i < 16; i++) m_pat[i] = 0;
    endtask

    task automatic model_load(input int i);
        int v;
        v = (wr_en && (int'(wr_addr) == i)) ? int'(wr_data) : m_pat[i];
        m_idx = i; m_pitch = v; m_gate = (v != 0); m_pulse = 1;
        m_dur = int'(tempo) + 1; m_elapsed = 0;
    endtask

    task automatic model_edge();
        m_pulse = 0;
        if (!m_play) begin
            if (run) begin
                m_play = 1;
                model_load(0);
            end
        end else if (!run) begin
            m_play = 0; m_idx = 0; m_pitch = 0; m_gate = 0;
        end else if (frame_tick) begin
            m_elapsed++;
            if (m_elapsed == m_dur)
                model_load((m_idx >= int'(loop_last)) ? 0 : m_idx + 1);
            else if (m_elapsed == m_dur - 1)
                m_gate = 0;
        end
        if (wr_en) m_pat[wr_addr] = int'(wr_data);
    endtask

    task automatic check_outputs();
        check("pitch_out", int'(pitch_out), m_pitch);
        check("gate_out", int'(gate_out), m_gate);
        check("step_idx", int'(step_idx), m_idx);
        check("step_pulse", int'(step_pulse), m_pulse);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic frames(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
            for (int g = 0; g < gap; g++) cycle();
        end
    endtask

    task automatic write_entry(input int a, input int d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = 8'(d);
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_outputs();
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs();
        rst_n = 1'b1;

        // 1: idle ignores frame ticks
        frames(20, 1);

        // 2: four-step pattern, 3 frames per step, gap on the last frame
        write_entry(0, 10); write_entry(1, 20);
        write_entry(2, 0);  write_entry(3, 40);
        loop_last = 4'd3; tempo = 4'd2; run = 1'b1;
        cycle();
        check("s2_start_pitch", int'(pitch_out), 10);
        frames(15, 2);

        // 3: one frame per step, full-length loop of non-rest notes
        run = 1'b0; cycle();
        for (int i = 0; i < 16; i++) write_entry(i, 50);
        tempo = 4'd0; loop_last = 4'd15; run = 1'b1;
        cycle();
        frames(40, 0);
        frames(10, 1);

        // 4: bypass of a write coinciding with the advancing tick
        run = 1'b0; cycle();
        tempo = 4'd3; run = 1'b1; cycle();
        frames(4, 1);
        frames(3, 1);
        frame_tick = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'd99;
        cycle();
        check("s4_bypass_pitch", int'(pitch_out), 99);
        frame_tick = 1'b0; wr_en = 1'b0;
        cycle();

        // 5: stop mid step 5, then restart at step 0
        frames(12, 1);
        frames(2, 1);
        run = 1'b0; frame_tick = 1'b1;
        cycle();
        check("s5_stop_idx", int'(step_idx), 0);
        frame_tick = 1'b0;
        cycle();
        run = 1'b1;
        cycle();
        check("s5_restart_pulse", int'(step_pulse), 1);
        frames(6, 1);

        // 6: async reset mid gap clears the pattern
        run = 1'b0; cycle();
        tempo = 4'd2; run = 1'b1; cycle();
        frames(2, 1);
        async_reset();
        cycle();
        check("s6_cleared_pitch", int'(pitch_out), 0);
        frames(8, 1);

        // random play with writes, tempo/loop changes and stops
        for (int c = 0; c < 3000; c++) begin
            run        = ($urandom_range(0, 99) < 97);
            frame_tick = ($urandom_range(0, 2) == 0);
            wr_en      = ($urandom_range(0, 5) == 0);
            wr_addr    = 4'($urandom_range(0, 15));
            wr_data    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, 30) == 0) tempo = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 40) == 0) loop_last = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
